// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANTED
    } arb_state_t;

    typedef logic [1:0] arb_idx_t;

    // One-hot vector selecting requester idx.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input arb_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotated priority search: finds the first set bit of (req & mask),
// starting at last+1 and wrapping through last+2, last+3, last.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic [1:0] i_last,
    input  logic [3:0] i_mask,
    output logic       o_found,
    output logic [1:0] o_idx
);

    logic [NUM_REQ-1:0] w_cand;
    logic [1:0]         w_pos;

    assign w_cand = i_req & i_mask;

    // Walk the four positions after the last holder; the first candidate wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = 2'd0;
        w_pos   = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = i_last + 2'(k);
            if (!o_found && w_cand[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with optional hold-time pre-emption.
// The grant vector, holder index and busy flag all come straight from
// flops, so there is no combinational path from req to any output.
module rr_arb4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       busy
);

    // Hold counter width; derived from HOLD_MAX, at least one bit.
    localparam int CNT_BITS    = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    // Counter value at which a waiting requester may take over the grant.
    localparam int HOLD_LAST_I = (HOLD_MAX < 1) ? 0 : HOLD_MAX - 1;
    localparam logic [CNT_BITS-1:0] HOLD_LAST = HOLD_LAST_I[CNT_BITS-1:0];
    localparam logic PREEMPT_EN = (HOLD_MAX > 0);

    arb_state_t          r_state;
    logic [3:0]          r_grant;
    logic [1:0]          r_idx;
    logic [1:0]          r_last;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_busy;

    arb_state_t          w_state_nxt;
    logic [3:0]          w_grant_nxt;
    logic [1:0]          w_idx_nxt;
    logic [1:0]          w_last_nxt;
    logic [CNT_BITS-1:0] w_cnt_nxt;
    logic [3:0]          w_pick_mask;
    logic                w_found;
    logic [1:0]          w_pick_idx;

    // While granted, the holder never competes in the handover search, so
    // a holder that releases cannot immediately win again.
    assign w_pick_mask = (r_state == ARB_IDLE) ? 4'b1111 : ~idx_to_onehot(r_idx);

    rr_pick4 u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .i_mask  (w_pick_mask),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    // State register: all arbiter state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_grant <= 4'b0000;
            r_idx   <= 2'd0;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_grant_nxt != 4'b0000);
        end
    end

    // Next-state logic: grant on request, handover on release or hold expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ARB_GRANTED;
                    w_grant_nxt = idx_to_onehot(w_pick_idx);
                    w_idx_nxt   = w_pick_idx;
                    w_last_nxt  = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            ARB_GRANTED: begin
                if (!req[r_idx]) begin
                    // Holder released: hand over with no bubble, or go idle.
                    if (w_found) begin
                        w_grant_nxt = idx_to_onehot(w_pick_idx);
                        w_idx_nxt   = w_pick_idx;
                        w_last_nxt  = w_pick_idx;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                        w_grant_nxt = 4'b0000;
                        w_idx_nxt   = 2'd0;
                    end
                    w_cnt_nxt = '0;
                end else if (PREEMPT_EN && (r_cnt == HOLD_LAST) && w_found) begin
                    // Hold time used up and someone is waiting: revoke.
                    w_grant_nxt = idx_to_onehot(w_pick_idx);
                    w_idx_nxt   = w_pick_idx;
                    w_last_nxt  = w_pick_idx;
                    w_cnt_nxt   = '0;
                end else if (PREEMPT_EN && (r_cnt != HOLD_LAST)) begin
                    // Count the hold time; saturates at HOLD_LAST.
                    w_cnt_nxt = r_cnt + CNT_BITS'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = 4'b0000;
                w_idx_nxt   = 2'd0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: driven directly from the registers.
    always_comb begin
        grant     = r_grant;
        grant_idx = r_idx;
        busy      = r_busy;
    end

`ifdef FORMAL
    // Grant is one-hot or zero, and busy/grant_idx agree with it.
    always_comb begin
        assert ($onehot0(grant));
        assert (busy == (grant != 4'b0000));
        assert ((grant == 4'b0000) ? (grant_idx == 2'd0)
                                   : (grant == idx_to_onehot(grant_idx)));
    end

    // A newly granted requester must have been requesting at that edge.
    always @(posedge clk) begin
        if (!reset) begin
            assert (((w_grant_nxt & ~r_grant) & ~req) == 4'b0000);
        end
    end
`endif

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: three instances (HOLD_MAX 16, 4 and 0) driven one at a
// time by directed vectors; expected grant/idx/busy go into a queue and a
// monitor on the falling edge compares them against the selected instance.
module tb_rr_arb4;

  localparam int W = 7;  // {busy, grant_idx[1:0], grant[3:0]}

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_a, req_b, req_c;
  logic [3:0] grant_a, grant_b, grant_c;
  logic [1:0] idx_a, idx_b, idx_c;
  logic       busy_a, busy_b, busy_c;

  int         sel;
  string      cur_name;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rr_arb4 dut_a (
    .clk       (clk),
    .reset     (reset),
    .req       (req_a),
    .grant     (grant_a),
    .grant_idx (idx_a),
    .busy      (busy_a)
  );

  rr_arb4 #(.HOLD_MAX(4)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .req       (req_b),
    .grant     (grant_b),
    .grant_idx (idx_b),
    .busy      (busy_b)
  );

  rr_arb4 #(.HOLD_MAX(0)) dut_c (
    .clk       (clk),
    .reset     (reset),
    .req       (req_c),
    .grant     (grant_c),
    .grant_idx (idx_c),
    .busy      (busy_c)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dut_view(input int s);
    case (s)
      0:       return {busy_a, idx_a, grant_a};
      1:       return {busy_b, idx_b, grant_b};
      default: return {busy_c, idx_c, grant_c};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] r);
    req_a = (sel == 0) ? r : 4'b0000;
    req_b = (sel == 1) ? r : 4'b0000;
    req_c = (sel == 2) ? r : 4'b0000;
  endtask

  // Apply req for one edge and queue the outputs expected after that edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] g, input logic [1:0] i);
    drive(r);
    @(posedge clk);
    exp_q.push_back({(g != 4'b0000), i, g});
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(4'b0000);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      check(cur_name, {25'd0, dut_view(sel)}, {25'd0, exp_q.pop_front()});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    sel      = 0;
    cur_name = "reset";
    req_a    = 4'b0000;
    req_b    = 4'b0000;
    req_c    = 4'b0000;
    @(posedge clk);
    #1;
    check("reset_a", {25'd0, dut_view(0)}, 32'd0);
    check("reset_b", {25'd0, dut_view(1)}, 32'd0);
    check("reset_c", {25'd0, dut_view(2)}, 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // First grant after reset and zero-bubble handover.
    cur_name = "handover";
    cyc(4'b0110, 4'b0010, 2'd1);
    cyc(4'b0100, 4'b0100, 2'd2);
    cyc(4'b0000, 4'b0000, 2'd0);

    // Round-robin order from a fresh reset, each holder releasing once.
    do_reset();
    cur_name = "rr_order";
    cyc(4'b1111, 4'b0001, 2'd0);
    cyc(4'b1110, 4'b0010, 2'd1);
    cyc(4'b1101, 4'b0100, 2'd2);
    cyc(4'b1011, 4'b1000, 2'd3);
    cyc(4'b0111, 4'b0001, 2'd0);
    // Requester 1 withdraws before being granted and is skipped.
    cur_name = "skip_withdrawn";
    cyc(4'b0100, 4'b0100, 2'd2);
    cyc(4'b0000, 4'b0000, 2'd0);
    // Same requester re-requests after release: one idle cycle between.
    cur_name = "rerequest";
    cyc(4'b0100, 4'b0100, 2'd2);
    cyc(4'b0000, 4'b0000, 2'd0);
    cyc(4'b0100, 4'b0100, 2'd2);
    cyc(4'b0000, 4'b0000, 2'd0);

    // HOLD_MAX=4: pre-emption on the fifth edge.
    sel = 1;
    cur_name = "preempt";
    cyc(4'b0001, 4'b0001, 2'd0);
    cyc(4'b0001, 4'b0001, 2'd0);
    cyc(4'b1001, 4'b0001, 2'd0);
    cyc(4'b1001, 4'b0001, 2'd0);
    cyc(4'b1001, 4'b1000, 2'd3);
    cyc(4'b0001, 4'b0001, 2'd0);
    cyc(4'b0000, 4'b0000, 2'd0);

    // HOLD_MAX=4: sole requester keeps the grant with a saturated counter.
    cur_name = "saturate";
    for (int k = 0; k < 20; k++) cyc(4'b0100, 4'b0100, 2'd2);
    // A newcomer is served on the very next edge once the counter is saturated.
    cur_name = "after_saturate";
    cyc(4'b0110, 4'b0010, 2'd1);
    cyc(4'b0000, 4'b0000, 2'd0);

    // Asynchronous reset in the middle of a grant to requester 3.
    sel = 0;
    cur_name = "async_reset";
    cyc(4'b1000, 4'b1000, 2'd3);
    cyc(4'b1000, 4'b1000, 2'd3);
    reset = 1'b1;
    #1;
    check("async_reset_now", {25'd0, dut_view(0)}, 32'd0);
    #2;
    reset = 1'b0;
    cur_name = "after_reset";
    cyc(4'b1000, 4'b1000, 2'd3);
    cyc(4'b0000, 4'b0000, 2'd0);

    // HOLD_MAX=0: no pre-emption however long the holder stays.
    sel = 2;
    cur_name = "no_preempt";
    for (int k = 0; k < 100; k++) cyc(4'b0011, 4'b0001, 2'd0);
    cur_name = "no_preempt_release";
    cyc(4'b0010, 4'b0010, 2'd1);
    cyc(4'b0000, 4'b0000, 2'd0);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
